// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: req/gnt ownership of the shared 8-digit seven-segment display, with scan and per-digit blink.
// Build option SEG_ARB_GAP_EN: blank the display for SCAN_DIV cycles on every ownership change.
module seg_display_arbiter #(
   parameter int unsigned SCAN_DIV  = 200000,
   parameter int unsigned HOLD_CYC  = 100000000,
   parameter int unsigned BLINK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] digits0,
   input  logic [31:0] digits1,
   input  logic [31:0] digits2,
   input  logic [31:0] digits3,
   input  logic [7:0]  blink0,
   input  logic [7:0]  blink1,
   input  logic [7:0]  blink2,
   input  logic [7:0]  blink3,
   output logic [3:0]  gnt,
   output logic [7:0]  seg,
   output logic [7:0]  an,
   output logic        busy
);

   localparam int unsigned SCAN_W  = $clog2(SCAN_DIV + 1);
   localparam int unsigned HOLD_W  = $clog2(HOLD_CYC + 1);
   localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYC - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   typedef enum logic [1:0] {IDLE, HOLD, OWN, SWITCH} state_t;

   state_t             state_q, state_d;
   logic [3:0]         gnt_q, gnt_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [SCAN_W-1:0]  scan_q, scan_d;
   logic [2:0]         digit_q, digit_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               phase_q, phase_d;
   logic [7:0]         an_q, an_d;
   logic [7:0]         seg_q, seg_d;
   logic               busy_q, busy_d;
`ifdef SEG_ARB_GAP_EN
   logic [SCAN_W-1:0]  gap_q, gap_d;
`else
   logic [3:0]         next_gnt_q, next_gnt_d;
`endif

   logic [3:0]  win;
   logic        go_switch;
   logic        go_own_eval;
   logic        others;
   logic        own_switch;
   logic        own_stay;
   logic [31:0] src_digits;
   logic [7:0]  src_blink;
   logic [3:0]  nib;

   // Requester 0 wins outright; otherwise search 1..3 starting just after ptr.
   function automatic logic [3:0] pick_winner(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [3:0] w;
      w   = '0;
      idx = ptr;
      if (r[0]) begin
         w = 4'b0001;
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
            if (w == '0 && r[idx]) w[idx] = 1'b1;
         end
      end
      return w;
   endfunction

   function automatic logic [1:0] ptr_after(input logic [3:0] w, input logic [1:0] ptr);
      logic [1:0] p;
      p = ptr;
      if (w[1]) p = 2'd1;
      if (w[2]) p = 2'd2;
      if (w[3]) p = 2'd3;
      return p;
   endfunction

   function automatic logic [7:0] seg_decode(input logic [3:0] code);
      logic [7:0] s;
      case (code)
         4'd0:    s = 8'b11111100;
         4'd1:    s = 8'b01100000;
         4'd2:    s = 8'b11011010;
         4'd3:    s = 8'b11110010;
         4'd4:    s = 8'b01100110;
         4'd5:    s = 8'b10110110;
         4'd6:    s = 8'b10111110;
         4'd7:    s = 8'b11100000;
         4'd8:    s = 8'b11111110;
         4'd9:    s = 8'b11110110;
         4'd10:   s = 8'b00000010;
         default: s = 8'b00000000;
      endcase
      return s;
   endfunction

   // Owner decision, used both in OWN and on the last HOLD cycle so a grant ends exactly at HOLD_CYC.
   always_comb begin
      others     = |(req[3:1] & ~gnt_q[3:1]);
      own_stay   = |(req & gnt_q);
      own_switch = gnt_q[0] ? (!req[0] && others) : (req[0] || others);
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      go_switch   = 1'b0;
      go_own_eval = 1'b0;
      win         = pick_winner(req, ptr_q);
`ifdef SEG_ARB_GAP_EN
      gap_d       = gap_q;
`else
      next_gnt_d  = next_gnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d   = win;
               ptr_d   = ptr_after(win, ptr_q);
               hold_d  = HOLD_LOAD;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (req[0] && |gnt_q[3:1]) begin
               go_switch = 1'b1;
            end else if (hold_q == '0) begin
               go_own_eval = 1'b1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         OWN: go_own_eval = 1'b1;
         SWITCH: begin
`ifdef SEG_ARB_GAP_EN
            if (gap_q == '0) begin
               state_d = IDLE;
               if (|req) begin
                  gnt_d   = win;
                  ptr_d   = ptr_after(win, ptr_q);
                  hold_d  = HOLD_LOAD;
                  state_d = HOLD;
               end
            end else begin
               gap_d = gap_q - SCAN_W'(1);
            end
`else
            gnt_d   = next_gnt_q;
            hold_d  = HOLD_LOAD;
            state_d = HOLD;
`endif
         end
      endcase

      if (go_own_eval) begin
         if (own_switch) begin
            go_switch = 1'b1;
         end else if (own_stay) begin
            state_d = OWN;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      end

      if (go_switch) begin
         state_d = SWITCH;
`ifdef SEG_ARB_GAP_EN
         gnt_d = '0;
         gap_d = SCAN_LAST;
`else
         next_gnt_d = win;
         ptr_d      = ptr_after(win, ptr_q);
`endif
      end

      busy_d = |gnt_d;
   end

   always_comb begin
      scan_d  = scan_q + SCAN_W'(1);
      digit_d = digit_q;
      if (scan_q == SCAN_LAST) begin
         scan_d  = '0;
         digit_d = digit_q + 3'd1;
      end

      // Any change of owner, or no owner at all, restarts blink in the visible phase.
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      phase_d     = phase_q;
      if (gnt_d != gnt_q || gnt_d == '0) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   always_comb begin
      src_digits = digits0;
      src_blink  = blink0;
      if (gnt_q[1]) begin
         src_digits = digits1;
         src_blink  = blink1;
      end else if (gnt_q[2]) begin
         src_digits = digits2;
         src_blink  = blink2;
      end else if (gnt_q[3]) begin
         src_digits = digits3;
         src_blink  = blink3;
      end

      nib   = src_digits[{~digit_q, 2'b00} +: 4];
      an_d  = '0;
      seg_d = '0;
      if (gnt_q != '0) begin
         seg_d = seg_decode(nib);
         if (!(phase_q && src_blink[~digit_q])) an_d = 8'h80 >> digit_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         ptr_q       <= 2'd3;
         hold_q      <= '0;
         scan_q      <= '0;
         digit_q     <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         an_q        <= '0;
         seg_q       <= '0;
         busy_q      <= 1'b0;
`ifdef SEG_ARB_GAP_EN
         gap_q       <= '0;
`else
         next_gnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         scan_q      <= scan_d;
         digit_q     <= digit_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         busy_q      <= busy_d;
`ifdef SEG_ARB_GAP_EN
         gap_q       <= gap_d;
`else
         next_gnt_q  <= next_gnt_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic, every cycle checked
// against a behavioural model built from elapsed-cycle arithmetic; follows SEG_ARB_GAP_EN like the design.
module tb_seg_display_arbiter;

   localparam int SCAN = 4;
   localparam int HOLD = 20;
   localparam int BLNK = 8;
   localparam int M_IDLE = 0, M_HOLD = 1, M_OWN = 2, M_SW = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] dig [4];
   logic [7:0]  blk [4];
   logic [3:0]  gnt;
   logic [7:0]  seg;
   logic [7:0]  an;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   // model: owner index (-1 none), mode, edges since grant, edges since reset
   int m_owner, m_mode, m_age, m_k, m_rr, m_left, m_pend;
   logic [3:0] e_gnt;
   logic [7:0] e_seg, e_an;
   logic       e_busy;

   always #5 clk = ~clk;

   seg_display_arbiter #(.SCAN_DIV(SCAN), .HOLD_CYC(HOLD), .BLINK_DIV(BLNK)) dut (
      .clk(clk), .rst(rst), .req(req),
      .digits0(dig[0]), .digits1(dig[1]), .digits2(dig[2]), .digits3(dig[3]),
      .blink0(blk[0]), .blink1(blk[1]), .blink2(blk[2]), .blink3(blk[3]),
      .gnt(gnt), .seg(seg), .an(an), .busy(busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pick_winner(input logic [3:0] r, input int rr);
      if (r[0]) return 0;
      for (int d = 1; d <= 3; d++) begin
         int c;
         c = (rr + d - 1) % 3 + 1;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic m_grant(input int w);
      m_owner = w;
      m_mode  = M_HOLD;
      m_age   = 0;
      if (w > 0) m_rr = w;
   endtask

   task automatic m_idle();
      m_owner = -1;
      m_mode  = M_IDLE;
   endtask

   task automatic m_switch(input logic [3:0] r);
      m_mode = M_SW;
`ifdef SEG_ARB_GAP_EN
      m_owner = -1;
      m_left  = SCAN - 1;
`else
      m_pend = pick_winner(r, m_rr);
      if (m_pend > 0) m_rr = m_pend;
`endif
   endtask

   task automatic m_decide(input logic [3:0] r);
      bit others;
      others = 1'b0;
      for (int c = 1; c <= 3; c++) if (c != m_owner && r[c]) others = 1'b1;
      if (m_owner == 0) begin
         if (r[0]) m_mode = M_OWN;
         else if (others) m_switch(r);
         else m_idle();
      end else if (r[0] || others) begin
         m_switch(r);
      end else if (r[m_owner]) begin
         m_mode = M_OWN;
      end else begin
         m_idle();
      end
   endtask

   task automatic model_step();
      int pd, ph, nib, w;
      logic [3:0] r;
      r = req;
      if (!rst) begin
         m_owner = -1; m_mode = M_IDLE; m_age = 0; m_k = 0; m_rr = 3; m_left = 0; m_pend = -1;
         e_gnt = '0; e_seg = '0; e_an = '0; e_busy = 1'b0;
         return;
      end
      pd = (m_k / SCAN) % 8;
      ph = (m_age / BLNK) % 2;
      if (m_owner < 0) begin
         e_an  = '0;
         e_seg = '0;
      end else begin
         nib   = int'((dig[m_owner] >> (4 * (7 - pd))) & 32'hF);
         e_seg = seg_tab[nib];
         e_an  = (ph == 1 && blk[m_owner][7 - pd]) ? 8'h00 : 8'(1 << (7 - pd));
      end
      m_k++;
      m_age++;
      case (m_mode)
         M_IDLE: if (r != 0) m_grant(pick_winner(r, m_rr));
         M_HOLD: begin
            if (m_owner > 0 && r[0]) m_switch(r);
            else if (m_age == HOLD) m_decide(r);
         end
         M_OWN: m_decide(r);
         default: begin
`ifdef SEG_ARB_GAP_EN
            if (m_left == 0) begin
               w = pick_winner(r, m_rr);
               if (w >= 0) m_grant(w);
               else m_idle();
            end else begin
               m_left--;
            end
`else
            m_grant(m_pend);
`endif
         end
      endcase
      e_gnt  = (m_owner < 0) ? 4'h0 : 4'(1 << m_owner);
      e_busy = (m_owner >= 0);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_eq("gnt",  32'(gnt),  32'(e_gnt));
      check_eq("an",   32'(an),   32'(e_an));
      check_eq("seg",  32'(seg),  32'(e_seg));
      check_eq("busy", 32'(busy), 32'(e_busy));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      run(2);
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         dig[i] = $urandom;
         blk[i] = '0;
      end

      do_reset();
      dig[1] = 32'h1234A567;
      req = 4'b0010;
      run(40);
      req = 4'b1110;
      run(100);

      do_reset();
      req = 4'b0100;
      run(10);
      req = 4'b1101;
      run(30);
      req = 4'b1100;
      run(40);

      do_reset();
      blk[1] = 8'b00000011;
      req = 4'b0010;
      run(80);
      blk[1] = '0;

      do_reset();
      req = 4'b0010;
      run(5);
      req = 4'b0000;
      run(30);

      do_reset();
      req = 4'b0010;
      run(25);
      rst = 1'b0;
      step();
      rst = 1'b1;
      run(5);
      req = 4'b0000;
      run(5);

      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 15) == 0)
            req = {3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0)};
         if ($urandom_range(0, 31) == 0) dig[$urandom_range(0, 3)] = $urandom;
         if ($urandom_range(0, 63) == 0) blk[$urandom_range(0, 3)] = 8'($urandom);
         rst = ($urandom_range(0, 599) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
